// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART transmit constants: FSM state encodings, frame levels and the parity helper.
package uart_tx_buffered_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head word is presented on dout, pop advances it.
module uart_tx_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          count
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    // Full is judged on the current count, so a write while full is dropped even if a pop happens.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serializer producing start, 8 data LSB-first, optional parity, stop.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(DATA_BITS - 1);
    localparam logic          PAR_ODD    = (PARITY_ODD != 0);
    localparam logic [2:0]    AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic          pop_c;
    logic          baud_done;
    logic [7:0]    fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    // Next-state logic; tx is derived from the next state so the line changes on the transition edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop_c   = 1'b0;
        tx_d    = STOP_LVL;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_dout;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (idx_q == LAST_IDX) state_d = AFTER_DATA;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_PARITY: begin
                if (baud_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = START_LVL;
            ST_DATA:   tx_d = shreg_d[idx_d];
            ST_PARITY: tx_d = parity_bit(shreg_d, PAR_ODD);
            default:   tx_d = STOP_LVL;
        endcase
    end

    // A new drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow)        overflow_d = 1'b0;
        if (wr_en && fifo_full)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= STOP_LVL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) | ~fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: even-parity, odd-parity and no-parity instances at 16 clocks per bit.
module tb_uart_tx_buffered;

    localparam int unsigned BT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clr_overflow = 1'b0;
    logic [2:0]       wr_en;
    logic [2:0][7:0]  wr_data;
    logic [2:0]       tx, busy, full, empty, ovf;
    logic [2:0][3:0]  count;

    uart_tx_buffered #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr_overflow(clr_overflow),
        .tx(tx[0]), .busy(busy[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
        .fifo_count(count[0]), .overflow(ovf[0]));

    uart_tx_buffered #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr_overflow(clr_overflow),
        .tx(tx[1]), .busy(busy[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
        .fifo_count(count[1]), .overflow(ovf[1]));

    uart_tx_buffered #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .clr_overflow(clr_overflow),
        .tx(tx[2]), .busy(busy[2]), .fifo_full(full[2]), .fifo_empty(empty[2]),
        .fifo_count(count[2]), .overflow(ovf[2]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bits in line order: bit 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit en, input bit odd);
        logic [10:0] f;
        f      = '0;
        f[8:1] = b;
        if (en) begin
            f[9]  = (^b) ^ odd;
            f[10] = 1'b1;
        end else begin
            f[9]  = 1'b1;
        end
        return f;
    endfunction

    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];
    logic [10:0] exp_q2[$];

    function automatic logic [10:0] pop_exp(input int k);
        logic [10:0] f;
        f = '1;
        case (k)
            0:       if (exp_q0.size() > 0) f = exp_q0.pop_front();
            1:       if (exp_q1.size() > 0) f = exp_q1.pop_front();
            default: if (exp_q2.size() > 0) f = exp_q2.pop_front();
        endcase
        return f;
    endfunction

    task automatic drive(input int k, input logic [7:0] b, input bit accepted);
        logic [10:0] f;
        wr_en[k]   = 1'b1;
        wr_data[k] = b;
        if (accepted) begin
            f = frame_of(b, k != 2, k == 1);
            case (k)
                0:       exp_q0.push_back(f);
                1:       exp_q1.push_back(f);
                default: exp_q2.push_back(f);
            endcase
        end
    endtask

    task automatic idle();
        wr_en = '0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line monitor: samples each bit mid-way and flags any change inside a bit period.
    bit          act[3];
    int          t[3];
    logic [10:0] bits[3];
    logic        cur[3];
    bit          unst[3];
    int          flen[3] = '{11, 11, 10};

    task automatic mon_step(input int k);
        if (reset) begin
            act[k] = 1'b0;
            return;
        end
        if (!act[k]) begin
            if (tx[k] !== 1'b0) return;
            act[k]  = 1'b1;
            t[k]    = 0;
            bits[k] = '0;
            unst[k] = 1'b0;
        end
        if (t[k] % BT == 0) cur[k] = tx[k];
        else if (tx[k] !== cur[k]) unst[k] = 1'b1;
        if (t[k] % BT == BT / 2) bits[k][t[k] / BT] = tx[k];
        if (t[k] == flen[k] * BT - 1) begin
            check($sformatf("frame%0d", k), 32'(bits[k]), 32'(pop_exp(k)));
            check($sformatf("bit_timing%0d", k), 32'(unst[k]), 32'd0);
            act[k] = 1'b0;
        end
        t[k]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) mon_step(k);
        end
    end

    initial begin
        wr_en   = '0;
        wr_data = '0;

        // Reset state
        wait_n(2);
        check("rst_tx",    32'(tx),       32'h7);
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_empty", 32'(empty[0]), 32'd1);
        check("rst_full",  32'(full[0]),  32'd0);
        check("rst_count", 32'(count[0]), 32'd0);
        check("rst_ovf",   32'(ovf[0]),   32'd0);
        reset = 1'b0;
        wait_n(2);

        // Single 0xA5, even parity: latency and end-of-frame busy
        drive(0, 8'hA5, 1'b1);
        @(negedge clk); idle();
        check("t1_tx_m0",    32'(tx[0]),    32'd1);
        check("t1_count_m0", 32'(count[0]), 32'd1);
        wait_n(1);
        check("t1_tx_m1",    32'(tx[0]),    32'd0);
        check("t1_count_m1", 32'(count[0]), 32'd0);
        check("t1_busy_m1",  32'(busy[0]),  32'd1);
        wait_n(175);
        check("t1_busy_m176", 32'(busy[0]), 32'd1);
        wait_n(1);
        check("t1_busy_m177", 32'(busy[0]), 32'd0);
        wait_n(5);

        // Three bytes on consecutive cycles, frames back-to-back
        drive(0, 8'h01, 1'b1);
        @(negedge clk);
        check("t2_count_m0", 32'(count[0]), 32'd1);
        drive(0, 8'h02, 1'b1);
        @(negedge clk);
        check("t2_count_m1", 32'(count[0]), 32'd1);
        drive(0, 8'h03, 1'b1);
        @(negedge clk); idle();
        check("t2_count_m2", 32'(count[0]), 32'd2);
        wait_n(175);
        check("t2_count_m177", 32'(count[0]), 32'd1);
        wait_n(176);
        check("t2_count_m353", 32'(count[0]), 32'd0);
        wait_n(175);
        check("t2_busy_m528", 32'(busy[0]), 32'd1);
        wait_n(1);
        check("t2_busy_m529", 32'(busy[0]), 32'd0);
        wait_n(5);

        // Nine writes fill the FIFO, tenth overflows, clear works
        for (int i = 0; i < 9; i++) begin
            drive(0, 8'h10 + 8'(i), 1'b1);
            @(negedge clk);
        end
        check("t3_count_full", 32'(count[0]), 32'd8);
        check("t3_full",       32'(full[0]),  32'd1);
        check("t3_ovf_before", 32'(ovf[0]),   32'd0);
        drive(0, 8'h99, 1'b0);
        @(negedge clk); idle();
        check("t3_ovf_set",   32'(ovf[0]),   32'd1);
        check("t3_count_hold", 32'(count[0]), 32'd8);
        clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        check("t3_ovf_clr", 32'(ovf[0]), 32'd0);

        // Clear coincident with a dropped write: set wins
        drive(0, 8'h77, 1'b0);
        clr_overflow = 1'b1;
        @(negedge clk); idle(); clr_overflow = 1'b0;
        check("t4_set_wins", 32'(ovf[0]), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        check("t4_ovf_clr", 32'(ovf[0]), 32'd0);
        wait_n(1700);
        check("t3_drained_busy", 32'(busy[0]), 32'd0);
        check("t3_drained_q", 32'(exp_q0.size()), 32'd0);

        // Reset mid-DATA of 0x00 with another byte queued
        drive(0, 8'h00, 1'b1);
        @(negedge clk);
        drive(0, 8'h55, 1'b1);
        @(negedge clk); idle();
        wait_n(30);
        check("t5_tx_low_in_data", 32'(tx[0]), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t5_tx_async",  32'(tx[0]),    32'd1);
        check("t5_empty",     32'(empty[0]), 32'd1);
        check("t5_count",     32'(count[0]), 32'd0);
        check("t5_busy",      32'(busy[0]),  32'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        wait_n(3);
        reset = 1'b0;
        wait_n(250);
        check("t5_post_busy", 32'(busy[0]), 32'd0);
        check("t5_post_tx",   32'(tx[0]),   32'd1);

        // Odd parity on 0xFF, and no-parity instance with two frames
        drive(1, 8'hFF, 1'b1);
        drive(2, 8'hFF, 1'b1);
        @(negedge clk);
        wr_en[1] = 1'b0;
        drive(2, 8'h3C, 1'b1);
        @(negedge clk); idle();
        wait_n(175);
        check("t6_odd_busy_m176", 32'(busy[1]), 32'd1);
        wait_n(1);
        check("t6_odd_busy_m177", 32'(busy[1]), 32'd0);
        wait_n(143);
        check("t6_nopar_busy_m320", 32'(busy[2]), 32'd1);
        wait_n(1);
        check("t6_nopar_busy_m321", 32'(busy[2]), 32'd0);

        wait_n(20);
        check("q_left0", 32'(exp_q0.size()), 32'd0);
        check("q_left1", 32'(exp_q1.size()), 32'd0);
        check("q_left2", 32'(exp_q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
